// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store initiator for a 16-bit big-endian data memory.
// Latency after accept: load/word store resp at +2, byte store (read-modify-write) at +3, error at +1.
// Backpressure: req_ready only in IDLE; a response is held stable until resp_ready is seen.
// Option: define LSU_ALIGN_CHK_EN to reject word accesses at odd byte addresses.
module dmem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WR     = 3'd4,
    RESP   = 3'd5
  } state_t;

  typedef struct packed {
    logic              write;
    logic              byte_acc;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [7:0]  merge_q;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;
  logic [15:0] addr_ext;

  assign accept     = (state == IDLE) && req_valid;
  assign addr_ext   = 16'(req_q.addr);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Reject word accesses that would run past the top of memory (and odd ones when checking alignment).
  always_comb begin
    req_err = !req_byte && (req_addr == {ADDR_W{1'b1}});
`ifdef LSU_ALIGN_CHK_EN
    if (!req_byte && req_addr[0]) begin
      req_err = 1'b1;
    end
`endif
  end

  // State register; async reset drops the strobes at once since they decode from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture, read-data capture and byte-merge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q   <= '{write: req_write, byte_acc: req_byte, addr: req_addr, wdata: req_wdata};
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state == RD) begin
        rdata_q <= req_q.byte_acc ? {8'h00, mem_rdata[15:8]} : mem_rdata;
      end
      if (state == RMW_RD) begin
        // Only the neighbouring byte survives the merge; the addressed byte is replaced.
        merge_q <= mem_rdata[7:0];
      end
    end
  end

  // Next-state and strobe decode; memory bus is zero whenever no strobe is active.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_nxt = RESP;
          end else if (!req_write) begin
            state_nxt = RD;
          end else if (req_byte) begin
            state_nxt = RMW_RD;
          end else begin
            state_nxt = WR;
          end
        end
      end
      RD: begin
        mem_read  = 1'b1;
        mem_addr  = addr_ext;
        state_nxt = RESP;
      end
      RMW_RD: begin
        mem_read  = 1'b1;
        mem_addr  = addr_ext;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_ext;
        mem_wdata = {req_q.wdata[7:0], merge_q};
        state_nxt = RESP;
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_ext;
        mem_wdata = req_q.wdata;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a byte-array big-endian memory and a response scoreboard.
// Expected responses are queued at request time and compared at the response handshake.
// Checks reset, load/store data paths, RMW merge, error cases, response stall and back-to-back throughput.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         overlap_cnt = 0;
  int         idle_bad = 0;
  int         rd_cyc, wr_cyc, lat_n;
  logic [15:0] wr_dat, rd_adr;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Big-endian memory: word at A is {M[A], M[A+1]}.
  assign mem_rdata = {mem[mem_addr[7:0]], mem[8'(mem_addr[7:0] + 8'd1)]};

  // Memory write port plus bus-hygiene monitors.
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:0]]               <= mem_wdata[15:8];
      mem[8'(mem_addr[7:0] + 8'd1)]    <= mem_wdata[7:0];
      wr_cnt                           <= wr_cnt + 1;
    end
    if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
    if (!mem_read && !mem_write && (mem_addr != 16'h0 || mem_wdata != 16'h0)) idle_bad <= idle_bad + 1;
    if (mem_addr[15:8] != 8'h00) idle_bad <= idle_bad + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard head and compare against the response currently presented.
  task automatic compare_resp(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check({tag, "_rdata"}, 32'(resp_rdata), 32'(e.rdata));
    check({tag, "_err"}, 32'(resp_err), 32'(e.err));
  endtask

  task automatic do_req(input logic w, input logic b, input logic [7:0] a, input logic [15:0] wd,
                        input logic e, input logic [15:0] rd, input int lat, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    sb.push_back('{err: e, rdata: rd});
    step();
    req_valid = 1'b0;
    lat_n  = 1;
    rd_cyc = -1;
    wr_cyc = -1;
    wr_dat = 16'h0;
    rd_adr = 16'h0;
    forever begin
      if (mem_read) begin
        rd_cyc = lat_n;
        rd_adr = mem_addr;
      end
      if (mem_write) begin
        wr_cyc = lat_n;
        wr_dat = mem_wdata;
      end
      if (resp_valid || lat_n >= 10) break;
      step();
      lat_n++;
    end
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_latency"}, lat_n, lat);
    compare_resp(tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_vld_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wc0;
    int acc;
    int last;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 16'h0000;
    resp_ready = 1'b0;
    step();
    step();

    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    step();

    // Known contents at 0x10, then reset during the read half of a byte store there
    do_req(1'b1, 1'b0, 8'h10, 16'hA55A, 1'b0, 16'h0000, 2, "pre10");
    check("pre10_wr_cyc", wr_cyc, 1);
    check("pre10_wr_dat", 32'(wr_dat), 32'hA55A);
    wc0       = wr_cnt;
    req_write = 1'b1;
    req_byte  = 1'b1;
    req_addr  = 8'h10;
    req_wdata = 16'h0077;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("rmwrst_rd_active", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmwrst_rd_drop", 32'(mem_read), 32'd0);
    check("rmwrst_wr_drop", 32'(mem_write), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rmwrst_no_write", wr_cnt, wc0);
    check("rmwrst_m10", 32'(mem[8'h10]), 32'hA5);
    check("rmwrst_m11", 32'(mem[8'h11]), 32'h5A);
    check("rmwrst_req_ready", 32'(req_ready), 32'd1);
    check("rmwrst_resp_valid", 32'(resp_valid), 32'd0);

    // Word store then word load
    do_req(1'b1, 1'b0, 8'h20, 16'hBEEF, 1'b0, 16'h0000, 2, "st20");
    check("st20_m20", 32'(mem[8'h20]), 32'hBE);
    check("st20_m21", 32'(mem[8'h21]), 32'hEF);
    do_req(1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 16'hBEEF, 2, "ld20");
    check("ld20_rd_cyc", rd_cyc, 1);
    check("ld20_rd_adr", 32'(rd_adr), 32'h20);

    // Byte store as read-modify-write, then byte load of the neighbour
    do_req(1'b1, 1'b0, 8'h40, 16'h1234, 1'b0, 16'h0000, 2, "st40");
    do_req(1'b1, 1'b1, 8'h40, 16'h00AB, 1'b0, 16'h0000, 3, "sb40");
    check("sb40_rd_cyc", rd_cyc, 1);
    check("sb40_wr_cyc", wr_cyc, 2);
    check("sb40_wr_dat", 32'(wr_dat), 32'hAB34);
    do_req(1'b0, 1'b1, 8'h41, 16'h0000, 1'b0, 16'h0034, 2, "lb41");

    // Top-of-memory word load errors without touching memory
    do_req(1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'h0000, 1, "ldff");
    check("ldff_no_read", rd_cyc, -1);

    // Odd word load
    do_req(1'b1, 1'b0, 8'h30, 16'h115A, 1'b0, 16'h0000, 2, "st30");
    do_req(1'b1, 1'b0, 8'h32, 16'hC399, 1'b0, 16'h0000, 2, "st32");
`ifdef LSU_ALIGN_CHK_EN
    do_req(1'b0, 1'b0, 8'h31, 16'h0000, 1'b1, 16'h0000, 1, "ld31");
    check("ld31_no_read", rd_cyc, -1);
`else
    do_req(1'b0, 1'b0, 8'h31, 16'h0000, 1'b0, 16'h5AC3, 2, "ld31");
    check("ld31_rd_adr", 32'(rd_adr), 32'h31);
`endif

    // Response stalled for 5 cycles while a new request is offered
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 8'h20;
    req_valid = 1'b1;
    sb.push_back('{err: 1'b0, rdata: 16'hBEEF});
    step();
    req_valid = 1'b0;
    step();
    check("stall_vld0", 32'(resp_valid), 32'd1);
    req_addr  = 8'h40;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_vld", 32'(resp_valid), 32'd1);
      check("stall_rdata", 32'(resp_rdata), 32'hBEEF);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_no_read", 32'(mem_read), 32'd0);
    end
    req_valid = 1'b0;
    compare_resp("stall");
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("stall_vld_drop", 32'(resp_valid), 32'd0);
    check("stall_rdy_back", 32'(req_ready), 32'd1);

    // Back-to-back word loads with both handshakes held high
    acc        = 0;
    last       = 0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_addr   = 8'h20;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (acc == 4 && sb.size() == 0) break;
      if (resp_valid) compare_resp("b2b");
      if (req_valid && req_ready) begin
        sb.push_back('{err: 1'b0, rdata: (req_addr == 8'h20) ? 16'hBEEF : 16'hAB34});
        if (acc > 0) check("b2b_gap", c - last, 3);
        last = c;
        acc++;
      end
      step();
      if (acc == 4) req_valid = 1'b0;
      else req_addr = (acc % 2 == 1) ? 8'h40 : 8'h20;
    end
    resp_ready = 1'b0;
    check("b2b_accepts", acc, 4);
    check("b2b_drained", sb.size(), 0);

    check("no_rd_wr_overlap", overlap_cnt, 0);
    check("idle_bus_zero", idle_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that drives the single-port data memory on behalf of the CPU datapath. It accepts one load or store request at a time over a valid/ready handshake and sequences the memory strobes. The memory is big-endian: word at byte address A is {M[A], M[A+1]}. Byte stores are performed as read-modify-write because the memory only writes full 16-bit words. Results return over a valid/ready response channel with an error flag.

## Interface
- ADDR_W, 8, byte-address width of the memory (256 bytes); upper bits of mem_addr are driven 0
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_addr  in  ADDR_W  byte address
- req_wdata  in  16  store data (byte store uses [7:0])
- resp_valid  out  1  response present, held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  16  load data (byte load: {8'h00, M[A]}; stores: 16'h0000)
- resp_err  out  1  request rejected, no memory access performed
- mem_addr  out  16  byte address to memory
- mem_wdata  out  16  write data to memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (memory writes at rising clk)
- mem_rdata  in  16  combinational read data from memory

## Operation
- States: IDLE, RD, RMW_RD, RMW_WR, WR, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register write/byte/addr/wdata; evaluate error; go to RESP if error, else RD (load), WR (word store), RMW_RD (byte store).
- RD: mem_read=1, mem_addr=addr; capture mem_rdata (word) or {8'h00, mem_rdata[15:8]} (byte) into resp_rdata; go RESP.
- WR: mem_write=1, mem_wdata=wdata; go RESP.
- RMW_RD: mem_read=1; capture mem_rdata into merge register; go RMW_WR.
- RMW_WR: mem_write=1, mem_wdata={wdata[7:0], merge[7:0]}; go RESP.
- RESP: resp_valid=1; on resp_ready go IDLE; otherwise hold all response outputs stable.
- Errors: word access at addr = 2^ADDR_W-1 always errors (second byte out of range). Misaligned word errors per Configuration. Error responses: resp_err=1, resp_rdata=0, no mem_read/mem_write pulse.
- mem_read, mem_write decoded from registered state only; never both high. mem_addr/mem_wdata are 0 whenever both strobes are low.
- One outstanding request; no request accepted while in RESP.

## Timing
- Reset: state=IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Accept edge = cycle 0. Load/word store: strobe in cycle 1, resp_valid from cycle 2. Byte store: read cycle 1, write cycle 2, resp_valid from cycle 3. Error: resp_valid from cycle 1.
- resp_valid deasserts the cycle after the resp_ready handshake; req_ready rises in that same cycle.
- Minimum request period: 3 cycles (load/word store, resp_ready tied 1), 4 cycles (byte store).
- Reset asserted mid-operation: all strobes drop immediately; a write whose strobe is removed before the clock edge does not occur; pending response discarded.

## Configuration
- LSU_ALIGN_CHK_EN defined: word access at odd address returns resp_err=1 with no memory access.
- Undefined: odd word addresses are accepted and accessed as {M[A], M[A+1]}; only the A=2^ADDR_W-1 word check remains.

## Test plan
- Reset mid-RMW_RD of byte store to 0x10: after release, mem_write never pulsed, M[0x10..0x11] unchanged, req_ready=1, resp_valid=0.
- Word store 0xBEEF to 0x20, then word load 0x20 -> M[0x20]=0xBE, M[0x21]=0xEF, resp_rdata=0xBEEF, resp_valid 2 cycles after accept.
- Preload word 0x1234 at 0x40; byte store 0xAB to 0x40 -> mem_wdata=0xAB34 in cycle 2, resp_valid cycle 3; byte load 0x41 -> resp_rdata=0x0034.
- Word load at 0xFF -> resp_err=1 in cycle 1, no mem_read; word load at 0x31 -> resp_err=1 with LSU_ALIGN_CHK_EN, else {M[0x31],M[0x32]}.
- Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout, new req_valid ignored.
- Back-to-back word loads with resp_ready=1 and req_valid=1 -> one accept every 3 cycles, mem_read never overlaps mem_write.
